// File: rtl/axis_check_sequencer_if.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : axis_check_sequencer_if                                    |
// | Description : Minimal AXI4-Stream bundle (valid/ready/data) used on both |
// |               sides of the check sequencer.                              |
// | Ports       : valid  - source has a beat                                 |
// |               ready  - sink accepts the beat                             |
// |               data   - beat payload, DATA_WIDTH bits                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

interface axis_check_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/axis_check_sequencer.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : axis_check_sequencer                                       |
// | Description : Run controller for a stream reference-check pass. Holds    |
// |               the comparator in reset until a run is requested, forwards |
// |               exactly NUM_BEATS beats, watches the comparator pass flag, |
// |               runs a stall watchdog and freezes a verdict.               |
// | Ports       : clk, reset      - clock, synchronous active-high reset     |
// |               start, abort    - run request / run termination           |
// |               in  (slave)     - stream from the design under check       |
// |               out (master)    - stream to the comparator                 |
// |               cmp_resetn      - active-low comparator reset              |
// |               cmp_pass        - comparator pass flag (1 cycle lag)       |
// |               done/pass/timed_out/aborted - frozen verdict               |
// |               beat_count      - beats accepted this run                  |
// |               fail_beat       - first failing beat, all-ones if none     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module axis_check_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_BEATS   = 1024,
  parameter int TIMEOUT     = 4096,
  parameter int COUNT_WIDTH = $clog2(NUM_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  axis_check_sequencer_if.slave  in,
  axis_check_sequencer_if.master out,
  output logic                   cmp_resetn,
  input  logic                   cmp_pass,
  output logic                   done,
  output logic                   pass,
  output logic                   timed_out,
  output logic                   aborted,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [COUNT_WIDTH-1:0] fail_beat
);

  localparam int                     WD_WIDTH  = $clog2(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] LAST_BEAT = COUNT_WIDTH'(NUM_BEATS - 1);
  localparam logic [COUNT_WIDTH-1:0] NO_FAIL   = '1;
  localparam logic [WD_WIDTH-1:0]    WD_LAST   = WD_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [WD_WIDTH-1:0]   wd_count;
  logic                  accept;
  logic                  fail_seen;
  logic [DATA_WIDTH-1:0] data_pass;

  // Payload is a pure wire; only the handshake is gated by the state.
  assign data_pass = in.data;
  assign out.data  = data_pass;

  // Computed from the raw inputs rather than in.ready so the handshake
  // decode does not loop back through the output mux.
  assign accept    = (state == S_RUN) && in.valid && out.ready;
  assign fail_seen = !cmp_pass && (fail_beat == NO_FAIL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmp_resetn = 1'b1;
    in.ready   = 1'b0;
    out.valid  = 1'b0;
    case (state)
      S_IDLE: begin
        cmp_resetn = 1'b0;
        if (start) state_next = S_ARM;
      end
      S_ARM: begin
        cmp_resetn = 1'b0;
        state_next = S_RUN;
      end
      S_RUN: begin
        in.ready  = out.ready;
        out.valid = in.valid;
        // Priority: abort, then final beat, then watchdog.
        if (abort) begin
          state_next = S_DONE;
        end else if (accept && (beat_count == LAST_BEAT)) begin
          state_next = S_SETTLE;
        end else if (!accept && (wd_count == WD_LAST)) begin
          state_next = S_DONE;
        end
      end
      S_SETTLE: state_next = S_DONE;
      S_DONE:   if (start) state_next = S_ARM;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count <= '0;
      wd_count   <= '0;
      fail_beat  <= NO_FAIL;
      done       <= 1'b0;
      pass       <= 1'b0;
      timed_out  <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      case (state)
        S_ARM: begin
          beat_count <= '0;
          wd_count   <= '0;
          fail_beat  <= NO_FAIL;
          done       <= 1'b0;
          pass       <= 1'b0;
          timed_out  <= 1'b0;
          aborted    <= 1'b0;
        end
        S_RUN: begin
          // cmp_pass lags by one beat, so the failing beat is the one
          // counted before this cycle.
          if (fail_seen) fail_beat <= beat_count - 1'b1;
          if (abort) begin
            // A beat handshaken alongside abort still passes downstream
            // but is deliberately left out of the count.
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (accept) begin
            beat_count <= beat_count + 1'b1;
            wd_count   <= '0;
          end else if (wd_count == WD_LAST) begin
            done      <= 1'b1;
            timed_out <= 1'b1;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
        end
        S_SETTLE: begin
          if (fail_seen) fail_beat <= beat_count - 1'b1;
          done <= 1'b1;
          pass <= cmp_pass && (fail_beat == NO_FAIL);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_check_sequencer.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_axis_check_sequencer                                    |
// | Description : Scoreboard bench for axis_check_sequencer. The driver      |
// |               pushes expected beats and verdicts; a negedge monitor pops |
// |               and compares whenever the DUT forwards a beat or raises    |
// |               done.                                                      |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_check_sequencer;

  localparam int DW   = 32;
  localparam int NB   = 8;
  localparam int TO   = 16;
  localparam int CW   = $clog2(NB + 1);
  localparam int ALL1 = (1 << CW) - 1;

  typedef struct {
    int done_cyc;
    bit pass;
    bit to;
    bit ab;
    int bc;
    int fb;
  } verdict_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          cmp_pass;
  logic          cmp_resetn;
  logic          done;
  logic          pass;
  logic          timed_out;
  logic          aborted;
  logic [CW-1:0] beat_count;
  logic [CW-1:0] fail_beat;

  axis_check_sequencer_if #(.DATA_WIDTH(DW)) s_in  ();
  axis_check_sequencer_if #(.DATA_WIDTH(DW)) s_out ();

  axis_check_sequencer #(
    .DATA_WIDTH (DW),
    .NUM_BEATS  (NB),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .in         (s_in),
    .out        (s_out),
    .cmp_resetn (cmp_resetn),
    .cmp_pass   (cmp_pass),
    .done       (done),
    .pass       (pass),
    .timed_out  (timed_out),
    .aborted    (aborted),
    .beat_count (beat_count),
    .fail_beat  (fail_beat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int             total = 0;
  int             bad   = 0;
  logic [DW-1:0]  dq[$];
  verdict_t       vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every forwarded beat and every rising done is checked
  // against what the driver queued.
  bit            done_q = 1'b0;
  verdict_t      mv;
  logic [DW-1:0] md;
  always @(negedge clk) begin
    if (s_out.valid === 1'b1 && s_out.ready === 1'b1) begin
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got beat data %h, expected no beat (cycle %0d)",
                 s_out.data, cyc);
      end else begin
        md = dq.pop_front();
        chk("beat_data", s_out.data, md);
      end
    end
    if (done === 1'b1 && !done_q) begin
      if (vq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=1, expected no verdict (cycle %0d)", cyc);
      end else begin
        mv = vq.pop_front();
        chk("done_cycle", cyc, mv.done_cyc);
        chk("pass", pass, mv.pass);
        chk("timed_out", timed_out, mv.to);
        chk("aborted", aborted, mv.ab);
        chk("beat_count", beat_count, mv.bc);
        chk("fail_beat", fail_beat, mv.fb);
      end
    end
    done_q = (done === 1'b1);
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_beat_count"}, beat_count, 0);
    chk({tag, "_fail_beat"}, fail_beat, ALL1);
    chk({tag, "_cmp_resetn"}, cmp_resetn, 0);
    chk({tag, "_in_ready"}, s_in.ready, 0);
  endtask

  // mode 0: full run, 1: timeout after nsend beats, 2: abort while the
  // last of nsend beats is presented, 3: reset after nsend beats.
  // fidx: beat after which the comparator drops pass (-1 = never).
  task automatic do_run(input int nsend, input int fidx, input int mode,
                        input int idle_pre, input logic [DW-1:0] d0);
    int            s;
    int            t_acc;
    int            wait_n;
    bit            hs;
    bit            last_abort;
    bit            captured;
    logic [DW-1:0] d;
    verdict_t      v;

    cmp_pass    = 1'b1;
    s_in.valid  = 1'b1;
    s_in.data   = d0;
    dq.push_back(d0);
    s_out.ready = 1'b1;
    repeat (idle_pre) step();
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    chk("ready_at_start", s_in.ready, 0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("ready_in_arm", s_in.ready, 0);
    chk("cmp_resetn_in_arm", cmp_resetn, 0);
    step();

    t_acc = s + 1;
    for (int i = 0; i < nsend; i++) begin
      if (i > 0) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          s_in.valid  = 1'b0;
          s_out.ready = 1'($urandom_range(0, 1));
          step();
        end
        d = $urandom;
        s_in.valid = 1'b1;
        s_in.data  = d;
        dq.push_back(d);
      end
      last_abort = (mode == 2) && (i == nsend - 1);
      abort  = last_abort;
      wait_n = 0;
      hs     = 1'b0;
      while (!hs && wait_n < 40) begin
        s_out.ready = (last_abort || i == 0 || wait_n >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        hs = s_in.valid && (s_in.ready === 1'b1);
        if (i == 0 && wait_n == 0) begin
          chk("first_hs_ready", s_in.ready, 1);
          chk("cmp_resetn_in_run", cmp_resetn, 1);
        end
        t_acc = cyc;
        wait_n++;
        step();
      end
      s_in.valid = 1'b0;
      abort      = 1'b0;
      if (!hs) begin
        total++;
        bad++;
        $display("FAIL handshake_wait: got no accept in 40 cycles, expected beat %0d accepted", i);
        break;
      end
      if (i == 0) chk("first_hs_cycle", t_acc, s + 2);
      if (i == fidx) cmp_pass = 1'b0;
    end

    if (mode == 3) begin
      reset = 1'b1;
      step();
      reset      = 1'b0;
      s_in.valid = 1'b1;
      s_in.data  = 32'h5A5A_0F0F;
      @(negedge clk);
      check_reset_vals("mid_reset");
      repeat (4) begin
        step();
        @(negedge clk);
        chk("idle_ready", s_in.ready, 0);
        chk("idle_cmp_resetn", cmp_resetn, 0);
        chk("idle_done", done, 0);
      end
      step();
      s_in.valid = 1'b0;
      return;
    end

    v.bc = (mode == 2) ? nsend - 1 : nsend;
    v.to = (mode == 1);
    v.ab = (mode == 2);
    captured = (fidx >= 0) && ((mode == 2) ? (fidx < nsend - 1) : (fidx < nsend));
    v.fb   = captured ? fidx : ALL1;
    v.pass = (mode == 0) && !captured;
    v.done_cyc = (mode == 0) ? t_acc + 2 : (mode == 1) ? t_acc + 1 + TO : t_acc + 1;
    vq.push_back(v);

    while (cyc < v.done_cyc) step();
    // In DONE: a stray beat, a failing cmp_pass and abort must all be ignored.
    cmp_pass    = 1'b0;
    abort       = 1'b1;
    s_in.valid  = 1'b1;
    s_in.data   = $urandom;
    s_out.ready = 1'b1;
    @(negedge clk);
    chk("done_high", done, 1);
    chk("ready_in_done", s_in.ready, 0);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("frozen_fail_beat", fail_beat, v.fb);
    chk("frozen_pass", pass, v.pass);
    chk("frozen_aborted", aborted, v.ab);
    step();
    s_in.valid = 1'b0;
  endtask

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int m;
    int n;
    int f;
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    cmp_pass    = 1'b1;
    s_in.valid  = 1'b0;
    s_in.data   = '0;
    s_out.ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("por");
    step();

    // Beat 0xA5 held while idle, start at cycle 10.
    do_run(NB, -1, 0, 10 - cyc, 32'hA5);
    do_run(NB, 3, 0, 1, $urandom);
    do_run(5, -1, 1, 0, $urandom);
    do_run(5, -1, 2, 2, $urandom);
    do_run(NB, -1, 0, 0, $urandom);
    do_run(3, -1, 3, 1, $urandom);
    do_run(NB, -1, 0, 0, $urandom);
    do_run(NB, NB - 1, 0, 0, $urandom);

    for (int r = 0; r < 14; r++) begin
      m = int'($urandom_range(0, 2));
      n = (m == 0) ? NB : (m == 1) ? int'($urandom_range(1, NB - 1)) : int'($urandom_range(2, NB));
      f = int'($urandom_range(0, n)) - 1;
      if ($urandom_range(0, 1) == 0) f = -1;
      do_run(n, f, m, int'($urandom_range(0, 3)), $urandom);
    end

    repeat (3) step();
    chk("beat_queue_empty", dq.size(), 0);
    chk("verdict_queue_empty", vq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
